sklansky_adder_pipe: RTL and testbench
======================================

// Module: sklansky_adder_pipe
// PURPOSE
//  Parametrised, pipelined Sklansky parallel-prefix adder with a valid/ready stream interface.
//  Generalises the fixed 16-bit combinational adder:
//   - width is configurable;
//   - register cut points sit every LVL_PER_STG prefix levels;
//   - it reports carry-out and signed overflow, and carries a transaction tag.
//  Sits behind the Wishbone/LA glue in the user project area as a throughput-1 arithmetic unit.
// PARAMETERS
//  WIDTH        32  operand width; power of 2, >=4; prefix levels L=log2(WIDTH)
//  LVL_PER_STG  2   prefix levels evaluated per pipeline stage, 1..L
//  TAG_W        4   width of the tag passed alongside each operation, >=1
// PORTS
//  wb_clk_i   in   1        single clock, rising edge
//  wb_rst_i   in   1        asynchronous active-high reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        unit can accept a beat
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  in_cin     in   1        carry-in (add mode)
//  in_sub     in   1        1 = subtract A-B (only with SKLANSKY_SUB_EN)
//  in_tag     in   TAG_W    user tag, returned unchanged with the result
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_sum    out  WIDTH    result mod 2^WIDTH
//  out_cout   out  1        carry out of MSB
//  out_ovf    out  1        two's-complement overflow
//  out_tag    out  TAG_W    tag of this result
// BEHAVIOUR
//  - Transfers happen on the rising edge where valid&&ready.
//  - Stage 0 (input register): p=a^b', g=a&b', c0 are registered with valid and tag; b' is defined under CONFIGURATION.
//  - Prefix stages: S=ceil(L/LVL_PER_STG) register stages, each doing LVL_PER_STG Sklansky levels.
//    - Sklansky level k: bit i with bit k of i set combines (G,P) with group ending at ((i>>k)<<k)-1.
//    - The last stage may hold fewer levels.
//    - c0 is folded in as the generate of bit -1.
//  - Sum: sum[i]=p[i]^G[i-1:-1], computed combinationally after the last prefix stage and registered into the output stage.
//  - Latency LAT=S+1 edges from input acceptance to out_valid (WIDTH=32, LVL_PER_STG=2 -> LAT=4).
//  - Throughput is one op per cycle.
//  - Each stage carries a valid bit. Bubbles are not collapsed; an empty stage simply moves forward.
//  - Global stall when out_valid && !out_ready: all stages hold, and out_* stay stable.
//  - in_ready = out_ready || !out_valid. This is combinational and must not depend on in_valid.
//  - Full pipe with out_ready=1 and in_valid=1: the result retires and a new beat enters on the same edge, with no gap.
//  - out_cout = G[WIDTH-1:-1].
//  - out_ovf = carry into MSB ^ out_cout.
//  - Results are not checked when out_valid=0, but out_* hold their last value.
//  - Reset (asynchronous, takes effect immediately, mid-operation included):
//    - all valid bits, out_valid, out_sum, out_cout, out_ovf and out_tag go to 0;
//    - in-flight operations are discarded;
//    - in_ready=1 once reset is released.
//  - No result is produced for a beat that is presented while in_ready=0.
// CONFIGURATION
//  SKLANSKY_SUB_EN defined:
//   - in_sub=1 -> b'=~in_b, c0=1, in_cin ignored;
//   - out_cout=1 means no borrow;
//   - out_ovf is signed subtract overflow.
//  SKLANSKY_SUB_EN undefined:
//   - in_sub is ignored and treated as 0: b'=in_b, c0=in_cin;
//   - no inverter is present on the B path.
// TESTING (WIDTH=32, LVL_PER_STG=2, TAG_W=4)
//  1. Carry out: A=FFFFFFFF, B=00000001, cin=0, tag=3
//     -> 4 edges later: sum=00000000, cout=1, ovf=0, tag=3.
//  2. Signed overflow: A=7FFFFFFF, B=00000001, cin=1
//     -> sum=80000001, cout=0, ovf=1.
//  3. Back-to-back: 8 random beats, tags 0..7, out_ready=1
//     -> 8 results on consecutive cycles, in order, matching the reference model.
//  4. Backpressure: pipe full, out_ready=0 for 3 cycles
//     -> in_ready=0, out_* stable;
//     -> on release, all 4 results appear once each, in order.
//  5. Reset mid-operation: reset asserted with 3 beats in flight
//     -> out_valid=0 immediately, out_sum=0;
//     -> after release, no stale result appears within 6 cycles.
//  6. Subtract: A=5, B=7, in_sub=1
//     -> with SKLANSKY_SUB_EN: sum=FFFFFFFE, cout=0, ovf=0;
//     -> without it (cin=0): sum=0000000C.

Source files
------------

// File: rtl/sklansky_adder_pipe_if.sv
// Stream interface for sklansky_adder_pipe: operand beat in, result beat out.
// The slave modport is the adder side, the master modport is the producer/consumer side.
interface sklansky_adder_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/sklansky_adder_pipe.sv
// Pipelined Sklansky parallel-prefix adder with valid/ready stream and pass-through tag.
// Optional subtract mode is enabled by defining SKLANSKY_SUB_EN.
module sklansky_adder_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LVL_PER_STG = 2,
  parameter int unsigned TAG_W       = 4
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  sklansky_adder_pipe_if.slave bus
);

  localparam int unsigned L = $clog2(WIDTH);
  localparam int unsigned S = (L + LVL_PER_STG - 1) / LVL_PER_STG;

  // Applies Sklansky levels [lo, hi) in place. Sources at level k have bit k clear,
  // so they are never overwritten within the same level.
  function automatic logic [2*WIDTH-1:0] sklansky_levels(input logic [WIDTH-1:0] g_in,
                                                         input logic [WIDTH-1:0] p_in,
                                                         input int unsigned lo,
                                                         input int unsigned hi);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    int unsigned      j;
    g = g_in;
    p = p_in;
    for (int unsigned k = 0; k < L; k++) begin
      if (k >= lo && k < hi) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (((i >> k) & 32'd1) == 32'd1) begin
            j    = ((i >> k) << k) - 32'd1;
            g[i] = g[i] | (p[i] & g[j]);
            p[i] = p[i] & p[j];
          end
        end
      end
    end
    return {p, g};
  endfunction

  logic [WIDTH-1:0] b_eff;
  logic             in_c0;

`ifdef SKLANSKY_SUB_EN
  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign in_c0 = bus.in_sub ? 1'b1 : bus.in_cin;
`else
  logic unused_sub;
  assign unused_sub = bus.in_sub;
  assign b_eff      = bus.in_b;
  assign in_c0      = bus.in_cin;
`endif

  // Stage registers: index 0 is the input register, index s>0 holds the output of prefix
  // stage s-1. The last prefix stage feeds the sum logic and the output register directly.
  logic [WIDTH-1:0] g_q   [S];
  logic [WIDTH-1:0] p_q   [S];
  logic [WIDTH-1:0] pr_q  [S];
  logic [TAG_W-1:0] tag_q [S];
  logic [S-1:0]     c0_q;
  logic [S-1:0]     vld_q;

  logic [WIDTH-1:0] g_c [S];
  logic [WIDTH-1:0] p_c [S];

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             advance;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int unsigned Lo = s * LVL_PER_STG;
    localparam int unsigned Hi = ((s + 1) * LVL_PER_STG > L) ? L : (s + 1) * LVL_PER_STG;

    logic [WIDTH-1:0]   g_in;
    logic [2*WIDTH-1:0] pg;

    // Carry-in enters as the generate of bit -1, merged into bit 0 before level 0.
    if (s == 0) begin : g_fold
      assign g_in = {g_q[0][WIDTH-1:1], g_q[0][0] | (p_q[0][0] & c0_q[0])};
    end else begin : g_pass
      assign g_in = g_q[s];
    end

    assign pg     = sklansky_levels(g_in, p_q[s], Lo, Hi);
    assign g_c[s] = pg[WIDTH-1:0];
    assign p_c[s] = pg[2*WIDTH-1:WIDTH];
  end

  logic unused_p_last;
  assign unused_p_last = ^p_c[S-1];

  // g_c of the last stage holds G[i:-1]; carry into bit i is G[i-1:-1].
  assign sum_c  = pr_q[S-1] ^ {g_c[S-1][WIDTH-2:0], c0_q[S-1]};
  assign cout_c = g_c[S-1][WIDTH-1];
  assign ovf_c  = g_c[S-1][WIDTH-1] ^ g_c[S-1][WIDTH-2];

  // Global stall: everything moves only when the output slot is free or being drained.
  assign advance      = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = advance;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int unsigned s = 0; s < S; s++) begin
        g_q[s]   <= '0;
        p_q[s]   <= '0;
        pr_q[s]  <= '0;
        tag_q[s] <= '0;
      end
      c0_q        <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (advance) begin
      vld_q[0] <= bus.in_valid;
      g_q[0]   <= bus.in_a & b_eff;
      p_q[0]   <= bus.in_a ^ b_eff;
      pr_q[0]  <= bus.in_a ^ b_eff;
      c0_q[0]  <= in_c0;
      tag_q[0] <= bus.in_tag;
      for (int unsigned s = 1; s < S; s++) begin
        vld_q[s] <= vld_q[s-1];
        g_q[s]   <= g_c[s-1];
        p_q[s]   <= p_c[s-1];
        pr_q[s]  <= pr_q[s-1];
        c0_q[s]  <= c0_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
      out_valid_q <= vld_q[S-1];
      // Output data only changes when a real result retires; bubbles leave it untouched.
      if (vld_q[S-1]) begin
        out_sum_q  <= sum_c;
        out_cout_q <= cout_c;
        out_ovf_q  <= ovf_c;
        out_tag_q  <= tag_q[S-1];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_sklansky_adder_pipe.sv
// Directed bench for sklansky_adder_pipe (WIDTH=32, LVL_PER_STG=2, TAG_W=4, latency 4).
module tb_sklansky_adder_pipe;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned LVL   = 2;
  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sklansky_adder_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  sklansky_adder_pipe #(
    .WIDTH      (WIDTH),
    .LVL_PER_STG(LVL),
    .TAG_W      (TAG_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [3:0] tag);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_tag   = tag;
  endtask

  // Reference: {ovf, cout, sum} of a + b + cin.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0] r;
    logic        ovf;
    r   = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    ovf = (a[31] == b[31]) && (r[31] != a[31]);
    return {ovf, r};
  endfunction

  task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [3:0] tag,
                        input logic [31:0] esum, input logic ecout, input logic eovf);
    drive(1'b1, a, b, cin, sub, tag);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    step();
    step();
    check({name, "_early_valid"}, {31'b0, bus.out_valid}, 32'd0);
    step();
    check({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({name, "_sum"}, bus.out_sum, esum);
    check({name, "_cout"}, {31'b0, bus.out_cout}, {31'b0, ecout});
    check({name, "_ovf"}, {31'b0, bus.out_ovf}, {31'b0, eovf});
    check({name, "_tag"}, {28'b0, bus.out_tag}, {28'b0, tag});
    step();
    check({name, "_after_valid"}, {31'b0, bus.out_valid}, 32'd0);
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];
  logic [31:0] a4 [4];
  logic [31:0] b4 [4];
  logic [33:0] m;
  logic        exp_v;

  initial begin
    va[0] = 32'h12345678; vb[0] = 32'h9ABCDEF0; vc[0] = 1'b0;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vc[1] = 1'b1;
    va[2] = 32'h80000000; vb[2] = 32'h80000000; vc[2] = 1'b0;
    va[3] = 32'h00000000; vb[3] = 32'h00000000; vc[3] = 1'b1;
    va[4] = 32'h7FFFFFFF; vb[4] = 32'h7FFFFFFF; vc[4] = 1'b0;
    va[5] = 32'hDEADBEEF; vb[5] = 32'h21524110; vc[5] = 1'b1;
    va[6] = 32'hAAAAAAAA; vb[6] = 32'h55555555; vc[6] = 1'b0;
    va[7] = 32'h00FF00FF; vb[7] = 32'hFF00FF01; vc[7] = 1'b0;
    a4[0] = 32'h11111111; b4[0] = 32'h22222222;
    a4[1] = 32'h00000001; b4[1] = 32'h00000002;
    a4[2] = 32'hFFFFFFFF; b4[2] = 32'hFFFFFFFF;
    a4[3] = 32'h40000000; b4[3] = 32'h40000000;

    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b1;
    #2;
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_sum", bus.out_sum, 32'd0);
    check("rst_tag", {28'b0, bus.out_tag}, 32'd0);
    check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    step();
    rst = 1'b0;

    single("carry", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd3, 32'h00000000, 1'b1, 1'b0);
    single("ovf", 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 4'd5, 32'h80000001, 1'b0, 1'b1);

    // Back-to-back: beat c accepted at edge c, retires after edge c+3.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(1'b1, va[c], vb[c], vc[c], 1'b0, 4'(c));
      else drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      check("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
      step();
      exp_v = (c >= 3) && (c < 11);
      check("b2b_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
      if (exp_v) begin
        m = model(va[c-3], vb[c-3], vc[c-3]);
        check("b2b_sum", bus.out_sum, m[31:0]);
        check("b2b_cout", {31'b0, bus.out_cout}, {31'b0, m[32]});
        check("b2b_ovf", {31'b0, bus.out_ovf}, {31'b0, m[33]});
        check("b2b_tag", {28'b0, bus.out_tag}, 32'(c - 3));
      end
    end

    // Backpressure: fill, stall three cycles with a rejected beat offered, then drain.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, a4[c], b4[c], 1'b0, 1'b0, 4'(8 + c));
      step();
    end
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hF0F0F0F0, 32'h00000001, 1'b0, 1'b0, 4'hF);
    #1;
    check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    m = model(a4[0], b4[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_hold_sum", bus.out_sum, m[31:0]);
      check("bp_hold_tag", {28'b0, bus.out_tag}, 32'd8);
      check("bp_hold_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      m = model(a4[r], b4[r], 1'b0);
      check("bp_drain_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_drain_sum", bus.out_sum, m[31:0]);
      check("bp_drain_ovf", {31'b0, bus.out_ovf}, {31'b0, m[33]});
      check("bp_drain_tag", {28'b0, bus.out_tag}, 32'(8 + r));
      step();
    end
    for (int k = 0; k < 3; k++) begin
      check("bp_no_extra", {31'b0, bus.out_valid}, 32'd0);
      step();
    end

    // Reset with three beats in flight; out_sum still holds the last drained result.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, va[c], vb[c], vc[c], 1'b0, 4'(c + 1));
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("rst_mid_pre_sum", bus.out_sum, 32'h80000000);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_mid_sum", bus.out_sum, 32'd0);
    check("rst_mid_tag", {28'b0, bus.out_tag}, 32'd0);
    check("rst_mid_cout", {31'b0, bus.out_cout}, 32'd0);
    step();
    step();
    rst = 1'b0;
    check("rst_rel_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rst_no_stale", {31'b0, bus.out_valid}, 32'd0);
    end

`ifdef SKLANSKY_SUB_EN
    single("sub", 32'd5, 32'd7, 1'b0, 1'b1, 4'd6, 32'hFFFFFFFE, 1'b0, 1'b0);
`else
    single("sub", 32'd5, 32'd7, 1'b0, 1'b1, 4'd6, 32'h0000000C, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
